// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment digit scan controller.
package display_pkg;

  localparam logic [2:0] SEL_ONES  = 3'b000;
  localparam logic [2:0] SEL_TENS  = 3'b001;
  localparam logic [2:0] SEL_HUNDS = 3'b010;
  localparam logic [2:0] SEL_THOUS = 3'b011;

  localparam logic [3:0] ANODE_OFF = 4'b1111;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t thous;
    bcd_t hunds;
    bcd_t tens;
    bcd_t ones;
  } digits_t;

  // Bit i set = digit i is a leading zero to suppress; ones is always shown.
  function automatic logic [3:0] lz_mask(input logic blank_lz, input digits_t d);
    logic [3:0] m;
    m[3] = blank_lz && (d.thous == 4'h0);
    m[2] = m[3] && (d.hunds == 4'h0);
    m[1] = m[2] && (d.tens == 4'h0);
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Slot counter for the digit scan: flags the last cycle of each slot and the
// anti-ghosting guard window at the start of each slot.
module refresh_prescaler #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD_CYC   = 500,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic slot_end,
  output logic in_guard
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD_CYC);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign slot_end = (cnt == CNT_LAST);
  assign in_guard = (cnt < CNT_GUARD);

endmodule

// File: rtl/digit_scan_ctrl.sv
// Four-digit seven-segment scan controller with frame-synchronous digit
// update, leading-zero blanking and a per-slot anode guard interval.
//
// state | meaning
// IDLE  | scan stopped, anodes off, pending digits commit the cycle after load
// SCAN  | walking digits ones..thous, pending digits commit on frame_end
module digit_scan_ctrl
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD_CYC   = 500,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       blank_lz,
  input  logic       load,
  input  logic [3:0] d_ones,
  input  logic [3:0] d_tens,
  input  logic [3:0] d_hunds,
  input  logic [3:0] d_thous,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [3:0] hunds,
  output logic [3:0] thous,
  output logic [2:0] stateSel,
  output logic [3:0] anode,
  output logic       blank,
  output logic       load_ack,
  output logic       frame_end
);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] idx;
  logic       slot_end;
  logic       in_guard;
  logic       run;
  logic       pend;
  logic       commit;
  digits_t    pending;
  digits_t    committed;
  logic [3:0] lz;

  assign run = (state == SCAN) && en;

  refresh_prescaler #(
    .REFRESH_DIV (REFRESH_DIV),
    .GUARD_CYC   (GUARD_CYC),
    .CNT_W       (CNT_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (!run),
    .slot_end (slot_end),
    .in_guard (in_guard)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en)  state_nxt = SCAN;
      SCAN: if (!en) state_nxt = IDLE;
      default:       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= 2'd0;
    end else if (!run) begin
      idx <= 2'd0;
    end else if (slot_end) begin
      idx <= idx + 2'd1;
    end
  end

  assign frame_end = (state == SCAN) && slot_end && (idx == 2'd3);

  // A commit on the same edge as a load takes the old pending value; the new
  // load then stays pending for the next commit opportunity.
  assign commit = pend && ((state == IDLE) || frame_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      committed <= '0;
      pend      <= 1'b0;
      load_ack  <= 1'b0;
    end else begin
      load_ack <= commit;
      if (commit) begin
        committed <= pending;
      end
      if (load) begin
        pending <= '{thous: d_thous, hunds: d_hunds, tens: d_tens, ones: d_ones};
        pend    <= 1'b1;
      end else if (commit) begin
        pend <= 1'b0;
      end
    end
  end

  assign ones  = committed.ones;
  assign tens  = committed.tens;
  assign hunds = committed.hunds;
  assign thous = committed.thous;

  assign lz = lz_mask(blank_lz, committed);

  always_comb begin
    stateSel = SEL_ONES;
    anode    = ANODE_OFF;
    blank    = 1'b1;
    if (state == SCAN) begin
      case (idx)
        2'd0:    stateSel = SEL_ONES;
        2'd1:    stateSel = SEL_TENS;
        2'd2:    stateSel = SEL_HUNDS;
        default: stateSel = SEL_THOUS;
      endcase
      if (!in_guard && !lz[idx]) begin
        anode = ~(4'b0001 << idx);
        blank = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with an 8-cycle slot and 2-cycle guard.
module tb_digit_scan_ctrl;

  localparam int DIV = 8;
  localparam int GRD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       blank_lz = 1'b0;
  logic       load = 1'b0;
  logic [3:0] d_ones = '0, d_tens = '0, d_hunds = '0, d_thous = '0;
  logic [3:0] ones, tens, hunds, thous;
  logic [2:0] stateSel;
  logic [3:0] anode;
  logic       blank, load_ack, frame_end;

  int checks = 0;
  int errors = 0;
  int k = 0;

  digit_scan_ctrl #(.REFRESH_DIV(DIV), .GUARD_CYC(GRD), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .blank_lz(blank_lz), .load(load),
    .d_ones(d_ones), .d_tens(d_tens), .d_hunds(d_hunds), .d_thous(d_thous),
    .ones(ones), .tens(tens), .hunds(hunds), .thous(thous),
    .stateSel(stateSel), .anode(anode), .blank(blank),
    .load_ack(load_ack), .frame_end(frame_end)
  );

  always #5 clk = ~clk;

  // k tracks the cycle position inside the frame while scanning.
  task automatic step();
    @(negedge clk);
    k = (k + 1) % 32;
  endtask

  task automatic advance_to(input int t);
    for (int n = 0; n < 32 && k != t; n++) step();
  endtask

  task automatic start_scan();
    en = 1'b0;
    step();
    en = 1'b1;
    k = 31;
  endtask

  task automatic set_digits(input logic [3:0] o, input logic [3:0] t,
                            input logic [3:0] h, input logic [3:0] th);
    d_ones = o; d_tens = t; d_hunds = h; d_thous = th;
  endtask

  task automatic load_idle(input logic [3:0] o, input logic [3:0] t,
                           input logic [3:0] h, input logic [3:0] th);
    en = 1'b0;
    step();
    step();
    set_digits(o, t, h, th);
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    checks++;
    if ({thous, hunds, tens, ones} !== {th, h, t, o}) begin
      errors++;
      $display("FAIL idle_load digits got %h expected %h", {thous, hunds, tens, ones}, {th, h, t, o});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (anode !== 4'b1111) begin errors++; $display("FAIL reset_anode got %b expected 1111", anode); end
    checks++;
    if (blank !== 1'b1) begin errors++; $display("FAIL reset_blank got %b expected 1", blank); end
    checks++;
    if (stateSel !== 3'b000) begin errors++; $display("FAIL reset_sel got %b expected 000", stateSel); end
    checks++;
    if ({thous, hunds, tens, ones} !== 16'h0000) begin
      errors++; $display("FAIL reset_digits got %h expected 0000", {thous, hunds, tens, ones});
    end
    checks++;
    if (load_ack !== 1'b0 || frame_end !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got ack=%b fe=%b expected 0 0", load_ack, frame_end);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_scan();
    logic [3:0] one;
    logic [3:0] exp_an;
    int s, c;
    one = 4'b0001;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (load_ack !== 1'b0) begin errors++; $display("FAIL basic_ack_early got %b expected 0", load_ack); end
    step();
    checks++;
    if (load_ack !== 1'b1) begin errors++; $display("FAIL basic_ack got %b expected 1", load_ack); end
    checks++;
    if ({thous, hunds, tens, ones} !== 16'h4321) begin
      errors++; $display("FAIL basic_digits got %h expected 4321", {thous, hunds, tens, ones});
    end
    start_scan();
    for (int kk = 0; kk < 32; kk++) begin
      step();
      s = kk / DIV;
      c = kk % DIV;
      exp_an = (c < GRD) ? 4'b1111 : ~(one << s);
      checks++;
      if (anode !== exp_an) begin errors++; $display("FAIL scan_anode k=%0d got %b expected %b", kk, anode, exp_an); end
      checks++;
      if (blank !== (c < GRD)) begin errors++; $display("FAIL scan_blank k=%0d got %b expected %b", kk, blank, (c < GRD)); end
      checks++;
      if (stateSel !== 3'(s)) begin errors++; $display("FAIL scan_sel k=%0d got %b expected %0d", kk, stateSel, s); end
      checks++;
      if (frame_end !== (kk == 31)) begin errors++; $display("FAIL scan_frame_end k=%0d got %b expected %b", kk, frame_end, (kk == 31)); end
    end
  endtask

  task automatic test_tear_free();
    start_scan();
    advance_to(8);
    set_digits(4'd5, 4'd6, 4'd7, 4'd8);
    load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if ({thous, hunds, tens, ones} !== 16'h4321 || load_ack !== 1'b0) begin
      errors++; $display("FAIL tear_hold got %h ack=%b expected 4321 ack=0", {thous, hunds, tens, ones}, load_ack);
    end
    advance_to(31);
    checks++;
    if ({thous, hunds, tens, ones} !== 16'h4321 || frame_end !== 1'b1) begin
      errors++; $display("FAIL tear_frame_end got %h fe=%b expected 4321 fe=1", {thous, hunds, tens, ones}, frame_end);
    end
    step();
    checks++;
    if ({thous, hunds, tens, ones} !== 16'h8765 || load_ack !== 1'b1) begin
      errors++; $display("FAIL tear_commit got %h ack=%b expected 8765 ack=1", {thous, hunds, tens, ones}, load_ack);
    end
    advance_to(1);
    set_digits(4'd1, 4'd1, 4'd1, 4'd1);
    load = 1'b1;
    step();
    load = 1'b0;
    advance_to(10);
    set_digits(4'd0, 4'd2, 4'd0, 4'd2);
    load = 1'b1;
    step();
    load = 1'b0;
    advance_to(31);
    checks++;
    if ({thous, hunds, tens, ones} !== 16'h8765) begin
      errors++; $display("FAIL two_loads_hold got %h expected 8765", {thous, hunds, tens, ones});
    end
    step();
    checks++;
    if ({thous, hunds, tens, ones} !== 16'h2020 || load_ack !== 1'b1) begin
      errors++; $display("FAIL two_loads_last got %h ack=%b expected 2020 ack=1", {thous, hunds, tens, ones}, load_ack);
    end
  endtask

  task automatic test_coincident();
    advance_to(5);
    set_digits(4'd3, 4'd3, 4'd3, 4'd3);
    load = 1'b1;
    step();
    load = 1'b0;
    advance_to(31);
    set_digits(4'd4, 4'd4, 4'd4, 4'd4);
    load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if ({thous, hunds, tens, ones} !== 16'h3333 || load_ack !== 1'b1) begin
      errors++; $display("FAIL coinc_old got %h ack=%b expected 3333 ack=1", {thous, hunds, tens, ones}, load_ack);
    end
    advance_to(31);
    checks++;
    if ({thous, hunds, tens, ones} !== 16'h3333) begin
      errors++; $display("FAIL coinc_hold got %h expected 3333", {thous, hunds, tens, ones});
    end
    step();
    checks++;
    if ({thous, hunds, tens, ones} !== 16'h4444 || load_ack !== 1'b1) begin
      errors++; $display("FAIL coinc_new got %h ack=%b expected 4444 ack=1", {thous, hunds, tens, ones}, load_ack);
    end
  endtask

  task automatic lz_case(input logic [3:0] o, input logic [3:0] t, input logic [3:0] h,
                         input logic [3:0] th, input logic lz, input logic [3:0] lit);
    logic [3:0] one;
    logic [3:0] exp_an;
    one = 4'b0001;
    load_idle(o, t, h, th);
    blank_lz = lz;
    start_scan();
    for (int i = 0; i < 4; i++) begin
      advance_to(DIV * i + GRD + 1);
      exp_an = lit[i] ? ~(one << i) : 4'b1111;
      checks++;
      if (anode !== exp_an || blank !== !lit[i]) begin
        errors++;
        $display("FAIL lz digits=%h%h%h%h lz=%b slot %0d got anode=%b blank=%b expected anode=%b blank=%b",
                 th, h, t, o, lz, i, anode, blank, exp_an, !lit[i]);
      end
    end
  endtask

  task automatic test_leading_zeros();
    lz_case(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 4'b0001);
    lz_case(4'd5, 4'd0, 4'd0, 4'd0, 1'b1, 4'b0001);
    lz_case(4'd0, 4'd3, 4'd0, 4'd0, 1'b1, 4'b0011);
    lz_case(4'd0, 4'd0, 4'd7, 4'd0, 1'b1, 4'b0111);
    lz_case(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 4'b1111);
    blank_lz = 1'b0;
  endtask

  task automatic test_disable();
    load_idle(4'd6, 4'd7, 4'd8, 4'd9);
    start_scan();
    advance_to(21);
    en = 1'b0;
    step();
    checks++;
    if (anode !== 4'b1111 || blank !== 1'b1 || stateSel !== 3'b000) begin
      errors++; $display("FAIL disable_off got anode=%b blank=%b sel=%b expected 1111 1 000", anode, blank, stateSel);
    end
    checks++;
    if ({thous, hunds, tens, ones} !== 16'h9876) begin
      errors++; $display("FAIL disable_keep got %h expected 9876", {thous, hunds, tens, ones});
    end
    en = 1'b1;
    k = 31;
    step();
    checks++;
    if (stateSel !== 3'b000 || anode !== 4'b1111) begin
      errors++; $display("FAIL restart_guard got sel=%b anode=%b expected 000 1111", stateSel, anode);
    end
    advance_to(GRD);
    checks++;
    if (stateSel !== 3'b000 || anode !== 4'b1110) begin
      errors++; $display("FAIL restart_lit got sel=%b anode=%b expected 000 1110", stateSel, anode);
    end
  endtask

  task automatic test_reset_pending();
    advance_to(4);
    set_digits(4'd9, 4'd9, 4'd9, 4'd9);
    load = 1'b1;
    step();
    load = 1'b0;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    checks++;
    if ({thous, hunds, tens, ones} !== 16'h0000 || anode !== 4'b1111 || stateSel !== 3'b000) begin
      errors++; $display("FAIL reset_async got %h anode=%b sel=%b expected 0000 1111 000",
                         {thous, hunds, tens, ones}, anode, stateSel);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (load_ack !== 1'b0 || {thous, hunds, tens, ones} !== 16'h0000) begin
        errors++; $display("FAIL reset_discard cyc=%0d got ack=%b digits=%h expected 0 0000",
                           i, load_ack, {thous, hunds, tens, ones});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_tear_free();
    test_coincident();
    test_leading_zeros();
    test_disable();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_scan_ctrl.md
# digit_scan_ctrl

Scan controller for the four-digit seven-segment display. It owns digit sequencing for the 4:1 digit multiplexer: it generates the 3-bit digit select, the active-low anode enables and the segment blank. It holds the four BCD digits in frame-synchronous registers, so a value update never tears mid-frame. It also applies optional leading-zero blanking and an anti-ghosting guard interval at each digit change.

## Interface
- REFRESH_DIV, 50000: clock cycles per digit slot; must be ≥ GUARD_CYC+2 and < 2**CNT_W.
- GUARD_CYC, 500: cycles at the start of each slot with all anodes off.
- CNT_W, 16: slot counter width.

- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  scan enable.
- blank_lz  in  1  1 = blank leading zeros.
- load  in  1  1-cycle strobe; captures d_ones..d_thous into the pending registers.
- d_ones, d_tens, d_hunds, d_thous  in  4 each  new BCD digits.
- ones, tens, hunds, thous  out  4 each  committed digits, driven to the mux data inputs.
- stateSel  out  3  mux select: 3'b000 ones, 3'b001 tens, 3'b010 hunds, 3'b011 thous.
- anode  out  4  active-low digit enables; bit i is digit i, where 0 = ones.
- blank  out  1  1 = force segments off.
- load_ack  out  1  1-cycle pulse when pending digits commit.
- frame_end  out  1  1-cycle pulse on the last cycle of the thous slot.

## Operation
- **FSM states:** IDLE and SCAN.
- **Registers:** slot counter cnt (0..REFRESH_DIV-1) and digit index idx (0..3).
- **IDLE → SCAN:** when en=1. Entry sets cnt=0 and idx=0.
- **SCAN → IDLE:** when en=0. Exit sets cnt=0 and idx=0.
- **Counting in SCAN:** cnt increments every cycle.
  - At cnt==REFRESH_DIV-1, cnt returns to 0 and idx advances; 3 wraps to 0.
  - frame_end=1 on the cycle where cnt==REFRESH_DIV-1 and idx==3.
- **Output decode:** outputs are combinational decode of registered state.
  - stateSel = {1'b0, idx} in SCAN; 3'b000 in IDLE.
  - anode = 4'b1111 and blank=1 in IDLE, during cnt < GUARD_CYC, or when the current digit is lz-blanked.
  - Otherwise anode = ~(4'b0001 << idx) and blank=0.
- **Leading-zero blanking** (only when blank_lz=1; evaluated on committed digits):
  - thous is blanked if thous==0.
  - hunds is blanked if thous==0 and hunds==0.
  - tens is blanked if thous, hunds and tens are all 0.
  - ones is never blanked.
- **Load capture:**
  - load=1 copies d_* into the pending registers and sets the pend flag.
  - A second load before commit overwrites the pending values; the last one wins.
- **Commit:**
  - In SCAN: on a frame_end cycle with pend=1, the pending values copy to the committed outputs and pend clears.
  - In IDLE: commit happens on the cycle after pend is set.
- **Coincident load and commit:** the commit uses the pending contents from before that edge. The new load stays pending and pend remains set.
- **load_ack:** asserted in the first cycle the new committed values are visible.

## Timing
- **Reset values:** state IDLE, cnt 0, idx 0, stateSel 3'b000, anode 4'b1111, blank 1, load_ack 0, frame_end 0, committed and pending digits 4'h0, pend 0.
- **Slot and frame length:** one slot is REFRESH_DIV cycles; one frame is 4*REFRESH_DIV cycles.
- **en rise:** if en rises at edge t, the first SCAN cycle (cnt=0, idx=0, guard) starts after edge t.
- **stateSel timing:** stateSel changes at slot start, so the mux settles within the guard interval.
- **Commit latency:**
  - In SCAN: up to one frame after load.
  - In IDLE: load_ack follows load by 2 cycles.
- **en fall mid-slot:** next cycle is IDLE with anodes off. Committed and pending data are kept.
- **Reset mid-operation:** asserting rst_n low forces all reset values immediately. A pending load is discarded.

## Structure
- **Package display_pkg:**
  - select constants SEL_ONES, SEL_TENS, SEL_HUNDS, SEL_THOUS;
  - ANODE_OFF = 4'b1111;
  - typedef enum state_t {IDLE, SCAN};
  - typedef logic [3:0] bcd_t.
- **Sub-module refresh_prescaler:**
  - holds cnt;
  - outputs slot_end and in_guard;
  - input clear.
- **Top level:** digit_scan_ctrl contains the FSM, the index, the pending/commit registers and the output decode.

## Test plan
All scenarios use REFRESH_DIV=8, GUARD_CYC=2.
- **Reset/idle:** rst_n low, en=0 → anode 4'b1111, blank=1, stateSel 000, digits 0.
- **Basic scan:** load 1,2,3,4 in IDLE, then en=1 → load_ack 2 cycles after load. stateSel walks 000,001,010,011, 8 cycles each. Per slot: anode 1111 for 2 cycles, then 1110/1101/1011/0111 for 6. frame_end at cycle 31 of the frame.
- **Tear-free update:**
  - Load 5,6,7,8 at idx=1 → outputs stay 1,2,3,4 until frame_end, then switch with load_ack.
  - Two loads in one frame → only the second commits.
- **Coincident load:** load asserted on the frame_end cycle → the old pending commits now; the new values commit at the next frame_end.
- **Leading zeros:** digits 0,0,0,0 with blank_lz=1 → only ones is lit. Digits 5,0,0,0 → ones lit only. Digits 0,3,0,0 → ones and tens lit. blank_lz=0 → all four lit.
- **Disable/reset mid-slot:**
  - en=0 at cnt=5, idx=2 → anodes off next cycle; en=1 restarts at idx 0, cnt 0.
  - rst_n low with pend=1 → no load_ack, digits 0.
